// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-bus fabric: FSM states, default
// response data and error-log word offsets.
package regbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] UNMAP_DATA_DEF = 32'hffff_ffff;
  localparam logic [31:0] TOUT_DATA_DEF  = 32'hdead_beef;

  localparam int ERRLOG_WORD0 = 0;
  localparam int ERRLOG_WORD1 = 1;

endpackage

// File: rtl/regbus_errlog.sv
// Error log for the register-bus fabric: saturating error counter, last failing
// address and sticky overrun flag. Instantiated only with REGBUS_ERRLOG_EN.
module regbus_errlog (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_log,
  input  logic [11:0] i_addr,
  input  logic        i_ovr,
  output logic [31:0] o_word0,
  output logic [31:0] o_word1
);

  logic        r_ovr;
  logic [15:0] r_err_count;
  logic [11:0] r_err_addr;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_ovr       <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      if (i_ovr) r_ovr <= 1'b1;
      if (i_log) begin
        if (r_err_count != 16'hffff) r_err_count <= r_err_count + 16'd1;
        r_err_addr <= i_addr;
      end
    end
  end

  assign o_word0 = {r_ovr, 15'b0, r_err_count};
  assign o_word1 = {20'b0, r_err_addr};

endmodule

// File: rtl/regbus_fabric.sv
// Register-bus interconnect: one master to 2**SEL_BITS slaves with timeout and
// unmapped-slot handling. Optional error-log slot enabled by REGBUS_ERRLOG_EN.
module regbus_fabric import regbus_pkg::*; #(
  parameter int                          AW         = 12,
  parameter int                          SEL_BITS   = 2,
  parameter logic [(2**SEL_BITS)-1:0]    SLOT_MASK  = 4'b0111,
  parameter int                          TIMEOUT    = 64,
  parameter logic [31:0]                 UNMAP_DATA = UNMAP_DATA_DEF,
  parameter logic [31:0]                 TOUT_DATA  = TOUT_DATA_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m_valid,
  input  logic                          m_wr,
  input  logic [AW-1:0]                 m_addr,
  input  logic [31:0]                   m_wdata,
  output logic [31:0]                   m_rdata,
  output logic                          m_ready,
  output logic                          m_err,
  output logic                          m_busy,
  output logic [(2**SEL_BITS)-1:0]      s_valid,
  output logic                          s_wr,
  output logic [AW-SEL_BITS-1:0]        s_addr,
  output logic [31:0]                   s_wdata,
  input  logic [32*(2**SEL_BITS)-1:0]   s_rdata,
  input  logic [(2**SEL_BITS)-1:0]      s_ready
);

  localparam int N_SLOTS = 2**SEL_BITS;
  localparam int SAW     = AW - SEL_BITS;
  localparam int CW      = $clog2(TIMEOUT + 1);

  state_e                r_state, w_state_nxt;
  logic [SEL_BITS-1:0]   r_slot;
  logic [SAW-1:0]        r_addr_lo;
  logic                  r_wr;
  logic [31:0]           r_wdata;
  logic [N_SLOTS-1:0]    r_s_valid;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy, r_err_pend, r_m_ready, r_m_err;
  logic [31:0]           r_m_rdata;

  logic [SEL_BITS-1:0]   w_req_slot;
  logic                  w_mapped, w_log_hit, w_accept, w_done_ok, w_done_tout;
  logic [31:0]           w_log_rdata;

  assign w_req_slot = m_addr[AW-1 -: SEL_BITS];
  assign w_mapped   = SLOT_MASK[w_req_slot];

`ifdef REGBUS_ERRLOG_EN
  logic [31:0] w_word0, w_word1;
  logic        w_log_event;
  logic [11:0] w_log_addr;

  if (SLOT_MASK[N_SLOTS-1]) begin : g_bad_mask
    $error("regbus_fabric: error-log slot must be clear in SLOT_MASK");
  end

  assign w_log_hit   = &w_req_slot;
  assign w_log_event = (w_accept && !w_mapped && !w_log_hit) || w_done_tout;
  assign w_log_addr  = w_done_tout ? 12'({r_slot, r_addr_lo}) : 12'(m_addr);

  always_comb begin
    w_log_rdata = '0;
    if (!m_wr) begin
      if (m_addr[SAW-1:0] == SAW'(ERRLOG_WORD0))      w_log_rdata = w_word0;
      else if (m_addr[SAW-1:0] == SAW'(ERRLOG_WORD1)) w_log_rdata = w_word1;
    end
  end

  regbus_errlog u_errlog (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_accept && w_log_hit && m_wr),
    .i_log   (w_log_event),
    .i_addr  (w_log_addr),
    .i_ovr   (m_valid && r_busy),
    .o_word0 (w_word0),
    .o_word1 (w_word1)
  );
`else
  assign w_log_hit   = 1'b0;
  assign w_log_rdata = '0;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_ok   = 1'b0;
    w_done_tout = 1'b0;
    case (r_state)
      IDLE: if (m_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = w_mapped ? ACCESS : RESP;
      end
      ACCESS: if (s_ready[r_slot]) begin
        w_done_ok   = 1'b1;
        w_state_nxt = RESP;
      end else if (r_cnt == CW'(TIMEOUT - 1)) begin
        w_done_tout = 1'b1;
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot     <= '0;
      r_addr_lo  <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_s_valid  <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_err_pend <= 1'b0;
      r_m_ready  <= 1'b0;
      r_m_err    <= 1'b0;
      r_m_rdata  <= '0;
    end else begin
      r_m_ready <= (r_state == RESP);
      r_m_err   <= (r_state == RESP) && r_err_pend;
      if (r_state == RESP) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
      if (r_state == ACCESS) r_cnt <= r_cnt + CW'(1);
      if (w_accept) begin
        r_slot     <= w_req_slot;
        r_addr_lo  <= m_addr[SAW-1:0];
        r_wr       <= m_wr;
        r_wdata    <= m_wdata;
        r_busy     <= 1'b1;
        r_err_pend <= !w_mapped && !w_log_hit;
        if (w_mapped)       r_s_valid <= N_SLOTS'(1) << w_req_slot;
        else if (w_log_hit) r_m_rdata <= w_log_rdata;
        else                r_m_rdata <= UNMAP_DATA;
      end
      if (w_done_ok) begin
        r_s_valid  <= '0;
        r_m_rdata  <= r_wr ? 32'd0 : s_rdata[32*r_slot +: 32];
        r_err_pend <= 1'b0;
      end
      if (w_done_tout) begin
        r_s_valid  <= '0;
        r_m_rdata  <= TOUT_DATA;
        r_err_pend <= 1'b1;
      end
    end
  end

  assign m_rdata = r_m_rdata;
  assign m_ready = r_m_ready;
  assign m_err   = r_m_err;
  assign m_busy  = r_busy;
  assign s_valid = r_s_valid;
  assign s_wr    = r_wr;
  assign s_addr  = r_addr_lo;
  assign s_wdata = r_wdata;

endmodule

// File: tb/tb_regbus_fabric.sv
// Self-checking bench for regbus_fabric: directed vector table, multi-cycle
// corner sequences and randomized transactions against a latency/data model.
module tb_regbus_fabric;
  import regbus_pkg::*;

  localparam int AW = 12, SEL_BITS = 2, N_SLOTS = 4, TIMEOUT = 64;
`ifdef REGBUS_ERRLOG_EN
  localparam logic [3:0] TB_MASK = 4'b0011;
`else
  localparam logic [3:0] TB_MASK = 4'b0111;
`endif

  logic         clk = 1'b0, reset = 1'b1;
  logic         m_valid = 1'b0, m_wr = 1'b0;
  logic [11:0]  m_addr = '0;
  logic [31:0]  m_wdata = '0;
  logic [31:0]  m_rdata;
  logic         m_ready, m_err, m_busy;
  logic [3:0]   s_valid;
  logic         s_wr;
  logic [9:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata = '0;
  logic [3:0]   s_ready = '0;

  always #5 clk = ~clk;

  regbus_fabric #(.AW(AW), .SEL_BITS(SEL_BITS), .SLOT_MASK(TB_MASK), .TIMEOUT(TIMEOUT),
                  .UNMAP_DATA(32'hffff_ffff), .TOUT_DATA(32'hdead_beef)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .m_busy(m_busy), .s_valid(s_valid), .s_wr(s_wr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdata"},  m_rdata, 32'd0);
    check({tag, "_ready"},  32'(m_ready), 32'd0);
    check({tag, "_err"},    32'(m_err), 32'd0);
    check({tag, "_busy"},   32'(m_busy), 32'd0);
    check({tag, "_svalid"}, 32'(s_valid), 32'd0);
    check({tag, "_swr"},    32'(s_wr), 32'd0);
    check({tag, "_saddr"},  32'(s_addr), 32'd0);
    check({tag, "_swdata"}, s_wdata, 32'd0);
  endtask

  // Slave models: each completes lat_cfg cycles after s_valid rises and owns a word memory.
  logic [31:0] slv_mem [4][1024];
  logic [31:0] ref_mem [4][1024];
  int          lat_cfg [4];
  int          w_cnt   [4];
  bit          noise_en = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (s_valid[i]) begin
        if (w_cnt[i] == lat_cfg[i]) begin
          s_ready[i] = 1'b1;
          s_rdata[32*i +: 32] = slv_mem[i][s_addr];
          if (s_wr) slv_mem[i][s_addr] = s_wdata;
        end else begin
          s_ready[i] = 1'b0;
          s_rdata[32*i +: 32] = $urandom;
        end
        w_cnt[i]++;
      end else begin
        s_ready[i] = noise_en ? 1'($urandom) : 1'b0;
        s_rdata[32*i +: 32] = $urandom;
        w_cnt[i] = 0;
      end
    end
  end

  // Issues one request at the current negedge (cycle T) and reports what came back.
  task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input int lat, output int lat_obs, output logic [31:0] rd,
                         output logic er, output int sv_cycles, output int proto_bad);
    int slot;
    slot = int'(addr[11:10]);
    lat_cfg[slot] = lat;
    lat_obs = -1; rd = '0; er = 1'b0; sv_cycles = 0; proto_bad = 0;
    m_valid = 1'b1; m_wr = wr; m_addr = addr; m_wdata = wd;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        m_valid = 1'b0; m_wr = 1'($urandom); m_addr = 12'($urandom); m_wdata = $urandom;
        if (!m_busy) proto_bad++;
      end
      if (s_valid != 4'b0) begin
        sv_cycles++;
        if (s_valid != (4'b1 << slot)) proto_bad++;
      end
      if (m_err && !m_ready) proto_bad++;
      if (m_ready) begin
        lat_obs = k; rd = m_rdata; er = m_err;
        if (m_busy) proto_bad++;
        break;
      end
    end
  endtask

  // Reference: outcome follows from slot population, slave latency and TIMEOUT only.
  task automatic predict(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input int lat, output int e_lat, output logic [31:0] e_rd,
                         output logic e_er, output int e_sv);
    int slot, lo;
    slot = int'(addr[11:10]); lo = int'(addr[9:0]);
    if (!TB_MASK[slot]) begin
      e_lat = 2; e_rd = 32'hffff_ffff; e_er = 1'b1; e_sv = 0;
    end else if (lat < TIMEOUT) begin
      e_lat = lat + 3; e_er = 1'b0; e_sv = lat + 1;
      e_rd = wr ? 32'd0 : ref_mem[slot][lo];
      if (wr) ref_mem[slot][lo] = wd;
    end else begin
      e_lat = TIMEOUT + 2; e_rd = 32'hdead_beef; e_er = 1'b1; e_sv = TIMEOUT;
    end
  endtask

  task automatic verify(input string tag, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, input int lat, input logic [31:0] e_rd,
                        input logic e_er, input int e_lat, input int e_sv);
    int lo; logic [31:0] rd; logic er; int sv, bad;
    run_txn(wr, addr, wd, lat, lo, rd, er, sv, bad);
    check({tag, "_latency"}, 32'(lo), 32'(e_lat));
    check({tag, "_rdata"},   rd, e_rd);
    check({tag, "_err"},     32'(er), 32'(e_er));
    check({tag, "_svcycles"}, 32'(sv), 32'(e_sv));
    check({tag, "_protocol"}, 32'(bad), 32'd0);
    if (e_sv > 0) begin
      check({tag, "_saddr"},  32'(s_addr), 32'(addr[9:0]));
      check({tag, "_swdata"}, s_wdata, wd);
      check({tag, "_swr"},    32'(s_wr), 32'(wr));
    end
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] e_rd;
    logic        e_er;
    int          e_lat;
    int          e_sv;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int pulses, first_k, s0_seen, el, es;
    logic [31:0] erd; logic eer;

    tbl[0] = '{1'b0, 12'h401, 32'h0,        0,   32'h1234_5678, 1'b0, 3,  1};
    tbl[1] = '{1'b1, 12'h004, 32'h0000_00a5, 5,  32'h0,         1'b0, 8,  6};
`ifdef REGBUS_ERRLOG_EN
    tbl[2] = '{1'b0, 12'h800, 32'h0,        0,   32'hffff_ffff, 1'b1, 2,  0};
    tbl[3] = '{1'b0, 12'h400, 32'h0,        255, 32'hdead_beef, 1'b1, 66, 64};
    tbl[4] = '{1'b0, 12'h402, 32'h0,        63,  32'hc0de_1002, 1'b0, 66, 64};
`else
    tbl[2] = '{1'b0, 12'hc00, 32'h0,        0,   32'hffff_ffff, 1'b1, 2,  0};
    tbl[3] = '{1'b0, 12'h800, 32'h0,        255, 32'hdead_beef, 1'b1, 66, 64};
    tbl[4] = '{1'b0, 12'h802, 32'h0,        63,  32'hc0de_2002, 1'b0, 66, 64};
`endif
    tbl[5] = '{1'b0, 12'h004, 32'h0,        62,  32'h0000_00a5, 1'b0, 65, 63};
    tbl[6] = '{1'b1, 12'h403, 32'h3c3c_3c3c, 2,  32'h0,         1'b0, 5,  3};
    tbl[7] = '{1'b0, 12'h403, 32'h0,        1,   32'h3c3c_3c3c, 1'b0, 4,  2};

    for (int s = 0; s < 4; s++) begin
      lat_cfg[s] = 0; w_cnt[s] = 0;
      for (int a = 0; a < 1024; a++) begin
        slv_mem[s][a] = 32'hc0de_0000 | (s << 12) | a;
        ref_mem[s][a] = 32'hc0de_0000 | (s << 12) | a;
      end
    end
    slv_mem[1][1] = 32'h1234_5678;
    ref_mem[1][1] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    check_idle("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    noise_en = 1;

    // Overlapping request one cycle after the first is dropped.
    lat_cfg[1] = 0;
    m_valid = 1'b1; m_wr = 1'b0; m_addr = 12'h401; m_wdata = '0;
    pulses = 0; first_k = -1; s0_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin m_valid = 1'b1; m_wr = 1'b1; m_addr = 12'h005; m_wdata = 32'h55; end
      if (k == 2) m_valid = 1'b0;
      if (s_valid[0]) s0_seen++;
      if (m_ready) begin
        pulses++;
        if (first_k < 0) begin first_k = k; check("ovl_rdata", m_rdata, 32'h1234_5678); end
      end
    end
    check("ovl_pulses", 32'(pulses), 32'd1);
    check("ovl_latency", 32'(first_k), 32'd3);
    check("ovl_slot0_untouched", 32'(s0_seen), 32'd0);
`ifdef REGBUS_ERRLOG_EN
    verify("log_ovr", 1'b0, 12'hc00, 32'h0, 0, 32'h8000_0000, 1'b0, 2, 0);
`endif

    // Reset while a request is in ACCESS abandons it silently.
    lat_cfg[1] = 1000;
    m_valid = 1'b1; m_wr = 1'b0; m_addr = 12'h400;
    @(negedge clk); m_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_svalid", 32'(s_valid), 32'b0010);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    reset = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (m_ready) pulses++;
    end
    check("rst_mid_no_ready", 32'(pulses), 32'd0);

    for (int i = 0; i < 8; i++) begin
      verify($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat,
             tbl[i].e_rd, tbl[i].e_er, tbl[i].e_lat, tbl[i].e_sv);
      predict(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat, el, erd, eer, es);
    end

`ifdef REGBUS_ERRLOG_EN
    verify("log_word0", 1'b0, 12'hc00, 32'h0, 0, 32'h0000_0002, 1'b0, 2, 0);
    verify("log_word1", 1'b0, 12'hc01, 32'h0, 0, 32'h0000_0400, 1'b0, 2, 0);
    verify("log_clear", 1'b1, 12'hc00, 32'h1, 0, 32'h0,         1'b0, 2, 0);
    verify("log_after", 1'b0, 12'hc00, 32'h0, 0, 32'h0,         1'b0, 2, 0);
`endif

    for (int n = 0; n < 150; n++) begin
      logic wr; logic [11:0] addr; logic [31:0] wd; int lat, r;
`ifdef REGBUS_ERRLOG_EN
      addr = {2'($urandom_range(0, 2)), 10'($urandom_range(0, 7))};
`else
      addr = {2'($urandom_range(0, 3)), 10'($urandom_range(0, 7))};
`endif
      wr = 1'($urandom); wd = $urandom;
      r = $urandom_range(0, 19);
      if (r < 14)       lat = $urandom_range(0, 4);
      else if (r == 14) lat = TIMEOUT - 2;
      else if (r == 15) lat = TIMEOUT - 1;
      else if (r == 16) lat = TIMEOUT;
      else              lat = 255;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      predict(wr, addr, wd, lat, el, erd, eer, es);
      verify($sformatf("rnd%0d", n), wr, addr, wd, lat, erd, eer, el, es);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
